// File: rtl/barrel_pkg.sv
// Shared definitions for the pipelined barrel rotator: mode encodings and bit reversal.
package barrel_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  localparam logic [1:0] MODE_ROT = 2'b00;
  localparam logic [1:0] MODE_LSH = 2'b01;
  localparam logic [1:0] MODE_ASH = 2'b10;

  // Reverse the low w bits of x; bits at and above w return as zero.
  function automatic logic [MAX_WIDTH-1:0] bit_reverse(input logic [MAX_WIDTH-1:0] x,
                                                       input int unsigned          w);
    logic [MAX_WIDTH-1:0] src;
    logic [MAX_WIDTH-1:0] res;
    src = x;
    res = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < w) begin
        res = {res[MAX_WIDTH-2:0], src[0]};
        src = src >> 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rotate_stage.sv
// One right rotate/shift-by-SHIFT step followed by its valid/ready pipeline register.
module rotate_stage
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHIFT = 1,
  parameter int unsigned AW    = 3,
  parameter bit          LAST  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_valid,
  output logic             up_ready_c,
  input  logic [WIDTH-1:0] up_data,
  input  logic [AW-1:0]    up_amount,
  input  logic             up_lr,
  input  logic [1:0]       up_mode,
  input  logic             up_fill,
  input  logic             dn_ready,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data,
  output logic [AW-1:0]    dn_amount,
  output logic             dn_lr,
  output logic [1:0]       dn_mode,
  output logic             dn_fill
);

  localparam int unsigned K = $clog2(SHIFT);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AW-1:0]    amount_q, amount_d;
  logic             lr_q, lr_d;
  logic [1:0]       mode_q, mode_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] step;

  // Register may take a new beat when empty or when its current beat moves on.
  assign up_ready_c = !valid_q || dn_ready;

  // Conditional rotate/shift by SHIFT; the last stage also undoes the entry reversal.
  always_comb begin
    step = up_data;
    if (up_amount[K]) begin
      if (up_mode == MODE_LSH || up_mode == MODE_ASH) begin
        step = {{SHIFT{up_fill}}, up_data[WIDTH-1:SHIFT]};
      end else begin
        step = {up_data[SHIFT-1:0], up_data[WIDTH-1:SHIFT]};
      end
    end
    if (LAST && up_lr) begin
      step = WIDTH'(bit_reverse(MAX_WIDTH'(step), WIDTH));
    end
  end

  // Next-state for the stage register: hold on stall, load on accept.
  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    amount_d = amount_q;
    lr_d     = lr_q;
    mode_d   = mode_q;
    fill_d   = fill_q;
    if (up_ready_c) begin
      valid_d = up_valid;
      if (up_valid) begin
        data_d   = step;
        amount_d = up_amount;
        lr_d     = up_lr;
        mode_d   = up_mode;
        fill_d   = up_fill;
      end
    end
  end

  // Stage register; data is cleared too so the output reads zero until the first beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      amount_q <= '0;
      lr_q     <= 1'b0;
      mode_q   <= MODE_ROT;
      fill_q   <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      amount_q <= amount_d;
      lr_q     <= lr_d;
      mode_q   <= mode_d;
      fill_q   <= fill_d;
    end
  end

  assign dn_valid  = valid_q;
  assign dn_data   = data_q;
  assign dn_amount = amount_q;
  assign dn_lr     = lr_q;
  assign dn_mode   = mode_q;
  assign dn_fill   = fill_q;

endmodule

// File: rtl/pipelined_barrel_rotator.sv
// Pipelined bidirectional barrel rotator/shifter, one log2 step per register, valid/ready stream.
module pipelined_barrel_rotator
  import barrel_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    amount,
  input  logic             lr,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out
);

  // Index 0 is the entry point, index k+1 is the output of stage k.
  logic [AW:0]      vld;
  logic [WIDTH-1:0] dat [AW+1];
  logic [AW-1:0]    amt [AW+1];
  logic [AW:0]      lrs;
  logic [1:0]       mde [AW+1];
  logic [AW:0]      fil;
  logic [AW-1:0]    up_rdy;
  logic [AW-1:0]    dn_rdy;
  logic [WIDTH-1:0] entry_data;
  logic             entry_fill;
  logic             unused_tail;

  // Left operations run through the right-only core on bit-reversed data; fill is fixed here.
  always_comb begin
    entry_data = data_in;
    entry_fill = 1'b0;
    if (lr) begin
      entry_data = WIDTH'(bit_reverse(MAX_WIDTH'(data_in), WIDTH));
    end
    if (mode == MODE_ASH && !lr) begin
      entry_fill = data_in[WIDTH-1];
    end
  end

  assign vld[0] = in_valid;
  assign dat[0] = entry_data;
  assign amt[0] = amount;
  assign lrs[0] = lr;
  assign mde[0] = mode;
  assign fil[0] = entry_fill;

  for (genvar k = 0; k < int'(AW); k++) begin : g_stage
    // Downstream ready of stage k, flattened from the registered valids so no comb loop forms.
    if (k == int'(AW) - 1) begin : g_tail
      assign dn_rdy[k] = out_ready;
    end else begin : g_mid
      assign dn_rdy[k] = out_ready || !(&vld[AW:k+2]);
    end

    rotate_stage #(
      .WIDTH (WIDTH),
      .SHIFT (32'd1 << k),
      .AW    (AW),
      .LAST  (k == int'(AW) - 1)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .up_valid   (vld[k]),
      .up_ready_c (up_rdy[k]),
      .up_data    (dat[k]),
      .up_amount  (amt[k]),
      .up_lr      (lrs[k]),
      .up_mode    (mde[k]),
      .up_fill    (fil[k]),
      .dn_ready   (dn_rdy[k]),
      .dn_valid   (vld[k+1]),
      .dn_data    (dat[k+1]),
      .dn_amount  (amt[k+1]),
      .dn_lr      (lrs[k+1]),
      .dn_mode    (mde[k+1]),
      .dn_fill    (fil[k+1])
    );
  end

  assign in_ready  = up_rdy[0];
  assign out_valid = vld[AW];
  assign data_out  = dat[AW];

  // Sideband of the final stage and inner ready taps are not needed at the outputs.
  assign unused_tail = ^{amt[AW], lrs[AW], mde[AW], fil[AW], up_rdy};

endmodule

// File: tb/tb_pipelined_barrel_rotator.sv
// Directed bench for the pipelined barrel rotator (WIDTH=8).
module tb_pipelined_barrel_rotator;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_in;
  logic [2:0] amount;
  logic       lr;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] data_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  pipelined_barrel_rotator #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .amount    (amount),
    .lr        (lr),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_model(input logic [7:0] d, input int unsigned a,
                                           input logic l, input logic [1:0] m);
    logic [15:0] dd;
    dd = {d, d};
    case (m)
      2'b01:   return l ? (d << a) : (d >> a);
      2'b10:   return l ? (d << a) : 8'($signed(d) >>> a);
      default: begin
        dd = l ? (dd << a) : (dd >> a);
        return l ? dd[15:8] : dd[7:0];
      end
    endcase
  endfunction

  // Single beat into an empty pipe: result must appear exactly on the third cycle.
  task automatic send_one(input string tag, input logic [7:0] d, input logic [2:0] a,
                          input logic l, input logic [1:0] m, input logic [7:0] exp);
    in_valid = 1'b1;
    data_in  = d;
    amount   = a;
    lr       = l;
    mode     = m;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " early1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, " early2"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " data"}, 32'(data_out), 32'(exp));
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vals [3];
    logic [7:0] exps [3];
    int unsigned idx;
    int unsigned n;
    logic [7:0] rd;

    reset     = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    amount    = '0;
    lr        = 1'b0;
    mode      = 2'b00;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset data_out", 32'(data_out), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle data_out", 32'(data_out), 32'd0);

    // Rotate right/left by 3
    send_one("rot r3", 8'b1001_0110, 3'd3, 1'b0, 2'b00, 8'b1101_0010);
    send_one("rot l3", 8'b1001_0110, 3'd3, 1'b1, 2'b00, 8'b1011_0100);

    // Logical and arithmetic shifts
    send_one("lsh r4", 8'hF0, 3'd4, 1'b0, 2'b01, 8'h0F);
    send_one("lsh l1", 8'h81, 3'd1, 1'b1, 2'b01, 8'h02);
    send_one("ash r7", 8'h80, 3'd7, 1'b0, 2'b10, 8'hFF);
    send_one("ash r2", 8'h40, 3'd2, 1'b0, 2'b10, 8'h10);
    send_one("ash l1", 8'hC1, 3'd1, 1'b1, 2'b10, 8'h82);
    send_one("rsv r1", 8'h01, 3'd1, 1'b0, 2'b11, 8'h80);
    send_one("amt0 ash", 8'h9C, 3'd0, 1'b1, 2'b10, 8'h9C);

    // Back-to-back rotate-left-by-1 stream
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        in_valid = 1'b1;
        data_in  = 8'(c + 1);
        amount   = 3'd1;
        lr       = 1'b1;
        mode     = 2'b00;
        check($sformatf("b2b in_ready c%0d", c), 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      if (c >= 3 && c < 11) begin
        check($sformatf("b2b valid c%0d", c), 32'(out_valid), 32'd1);
        check($sformatf("b2b data c%0d", c), 32'(data_out), 32'((c - 2) * 2));
      end else begin
        check($sformatf("b2b idle c%0d", c), 32'(out_valid), 32'd0);
      end
      @(negedge clk);
    end

    // Backpressure: consumer stalls for 6 cycles while producer keeps offering
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    exps[0] = 8'h44; exps[1] = 8'h88; exps[2] = 8'hCC;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      data_in  = vals[(idx < 3) ? idx : 2];
      amount   = 3'd2;
      lr       = 1'b1;
      mode     = 2'b01;
      if (in_ready) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("stall accepted", idx, 32'd3);
    check("stall in_ready", 32'(in_ready), 32'd0);
    check("stall out_valid", 32'(out_valid), 32'd1);
    check("stall data", 32'(data_out), 32'h44);
    @(negedge clk);
    check("stall hold valid", 32'(out_valid), 32'd1);
    check("stall hold data", 32'(data_out), 32'h44);
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) begin
        check($sformatf("drain beat%0d", n), 32'(data_out), 32'(exps[(n < 3) ? n : 2]));
        n++;
      end
      @(negedge clk);
    end
    check("drain count", n, 32'd3);

    // Reset with three beats in flight
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      data_in  = 8'hA5;
      amount   = 3'd0;
      lr       = 1'b0;
      mode     = 2'b00;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("pre-reset valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset in_ready", 32'(in_ready), 32'd1);
    check("midreset data_out", 32'(data_out), 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("post-reset idle c%0d", c), 32'(out_valid), 32'd0);
      @(negedge clk);
    end

    // Sweep all mode/lr/amount combinations on random data
    for (int m = 0; m < 4; m++) begin
      for (int l = 0; l < 2; l++) begin
        for (int a = 0; a < 8; a++) begin
          rd = 8'($urandom);
          send_one($sformatf("sweep m%0d lr%0d a%0d d%02h", m, l, a, rd), rd, 3'(a), 1'(l),
                   2'(m), ref_model(rd, a, 1'(l), 2'(m)));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
